// File: rtl/sram_arbiter_pkg.sv
// Shared sizes, owner tags and arbiter state encodings for the sram_arbiter slice.
// Optional port-1 lock support in the top is enabled by defining ARB_LOCK_EN.
`ifndef D_SIZE
`define D_SIZE 32
`endif
`ifndef A_SIZE
`define A_SIZE 10
`endif

package sram_arbiter_pkg;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  function automatic logic other_owner(input logic owner);
    return (owner == OWNER_M0) ? OWNER_M1 : OWNER_M0;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Combinational two-way round-robin selector: a lone requester always wins,
// a contended slot goes to the port that did not own the previous transfer.
module rr_pick
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt,
  output logic       winner
);

  always_comb begin
    gnt    = 2'b00;
    winner = last_owner;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        winner = OWNER_M0;
      end
      2'b10: begin
        gnt    = 2'b10;
        winner = OWNER_M1;
      end
      2'b11: begin
        winner = other_owner(last_owner);
        gnt    = (other_owner(last_owner) == OWNER_M1) ? 2'b10 : 2'b01;
      end
      default: begin
        gnt    = 2'b00;
        winner = last_owner;
      end
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter for a single-port sram with registered strobes and tagged
// read return. Define ARB_LOCK_EN to add the m1_lock burst-lock mode.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int D_SIZE   = `D_SIZE,
  parameter int A_SIZE   = `A_SIZE,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [A_SIZE-1:0] m0_addr,
  input  logic [D_SIZE-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [D_SIZE-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [A_SIZE-1:0] m1_addr,
  input  logic [D_SIZE-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [D_SIZE-1:0] m1_rdata,
`ifdef ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic              read,
  output logic              write,
  output logic [A_SIZE-1:0] address,
  output logic [D_SIZE-1:0] data_out,
  input  logic [D_SIZE-1:0] data_in
);

  if (LOCK_MAX < 1) begin : g_lock_max_check
    $error("sram_arbiter: LOCK_MAX must be at least 1");
  end

  logic              last_owner;
  logic [1:0]        req_vec;
  logic [1:0]        gnt_vec;
  logic              winner;
  logic              accept;
  logic              m0_block;

  logic              sel_we;
  logic [A_SIZE-1:0] sel_addr;
  logic [D_SIZE-1:0] sel_wdata;

  logic              rd_p0;
  logic              wr_p0;
  logic              own_p0;
  logic [A_SIZE-1:0] addr_p0;
  logic [D_SIZE-1:0] wdata_p0;
  logic              vld_p1;
  logic              own_p1;

  logic [D_SIZE-1:0] m0_rdata_hold;
  logic [D_SIZE-1:0] m1_rdata_hold;

`ifdef ARB_LOCK_EN
  localparam int CNT_W = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_cnt_next;

  assign m0_block      = (state == LOCKED);
  assign lock_cnt_next = lock_cnt + 1'b1;

  // The grant that enters LOCKED is the first one counted toward LOCK_MAX;
  // leaving on the limit keeps last_owner=1, so the next contention goes to port 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else if ((state == LOCKED) && !m1_lock) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else if (gnt_vec[1] && m1_lock) begin
      if (lock_cnt_next >= CNT_W'(LOCK_MAX)) begin
        state    <= IDLE;
        lock_cnt <= '0;
      end else begin
        state    <= LOCKED;
        lock_cnt <= lock_cnt_next;
      end
    end
  end
`else
  assign m0_block = 1'b0;
`endif

  assign req_vec = {m1_req, m0_req & ~m0_block};

  rr_pick u_rr_pick (
    .req        (req_vec),
    .last_owner (last_owner),
    .gnt        (gnt_vec),
    .winner     (winner)
  );

  assign m0_gnt    = gnt_vec[0];
  assign m1_gnt    = gnt_vec[1];
  assign accept    = |gnt_vec;
  assign sel_we    = (winner == OWNER_M1) ? m1_we    : m0_we;
  assign sel_addr  = (winner == OWNER_M1) ? m1_addr  : m0_addr;
  assign sel_wdata = (winner == OWNER_M1) ? m1_wdata : m0_wdata;

  // Stage p0: accepted access becomes the registered sram strobe cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_p0      <= 1'b0;
      wr_p0      <= 1'b0;
      own_p0     <= OWNER_M0;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      last_owner <= OWNER_M1;
    end else begin
      rd_p0 <= accept & ~sel_we;
      wr_p0 <= accept & sel_we;
      if (accept) begin
        own_p0     <= winner;
        addr_p0    <= sel_addr;
        wdata_p0   <= sel_wdata;
        last_owner <= winner;
      end
    end
  end

  assign read     = rd_p0;
  assign write    = wr_p0;
  assign address  = addr_p0;
  assign data_out = wdata_p0;

  // Stage p1: sram data_in is valid now; steer it to the tagged owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      own_p1 <= OWNER_M0;
    end else begin
      vld_p1 <= rd_p0;
      own_p1 <= own_p0;
    end
  end

  assign m0_rvalid = vld_p1 & (own_p1 == OWNER_M0);
  assign m1_rvalid = vld_p1 & (own_p1 == OWNER_M1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m0_rdata_hold <= '0;
      m1_rdata_hold <= '0;
    end else begin
      if (m0_rvalid) m0_rdata_hold <= data_in;
      if (m1_rvalid) m1_rdata_hold <= data_in;
    end
  end

  // rdata follows data_in on the rvalid cycle and otherwise holds the last return.
  assign m0_rdata = m0_rvalid ? data_in : m0_rdata_hold;
  assign m1_rdata = m1_rvalid ? data_in : m1_rdata_hold;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized and directed bench for sram_arbiter with a transaction-level model
// of arbitration, strobe timing and read return; honours ARB_LOCK_EN.
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
`ifdef ARB_LOCK_EN
  localparam int LMAX = 4;
`else
  localparam int LMAX = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
`ifdef ARB_LOCK_EN
  logic          m1_lock = 1'b0;
`endif
  logic          read, write;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_in = '0;

  always #5 clk = ~clk;

  sram_arbiter #(.D_SIZE(DW), .A_SIZE(AW), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .read(read), .write(write), .address(address), .data_out(data_out),
    .data_in(data_in)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // sram: data_in is valid the cycle after a read strobe
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (read === 1'b1) data_in <= mem[address];
    if (write === 1'b1) mem[address] <= data_out;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct { int due; bit port; logic [DW-1:0] d; } rd_t;
  rd_t           pend[$];
  bit            m_last = 1'b1;
  bit            m_rd = 1'b0, m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_dout = '0, m_rdat0 = '0, m_rdat1 = '0;
  bit            m_locked = 1'b0;
  int            m_cnt = 0;

  bit            w0, w1, e0, e1, ev0, ev1, p, s_we;
  logic [AW-1:0] s_a;
  logic [DW-1:0] s_d;

  bit            gnt_log[$];
  logic [DW-1:0] rv0_log[$], rv1_log[$];
  int            rv1_cyc[$];

  always @(negedge clk) begin
    w0 = (m0_req === 1'b1);
    w1 = (m1_req === 1'b1);
`ifdef ARB_LOCK_EN
    if (m_locked) w0 = 1'b0;
`endif
    e0 = w0 && (!w1 || m_last);
    e1 = w1 && (!w0 || !m_last);
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].port) begin ev1 = 1'b1; m_rdat1 = pend[0].d; end
      else begin ev0 = 1'b1; m_rdat0 = pend[0].d; end
      void'(pend.pop_front());
    end
    if (chk_en) begin
      chk("m0_gnt", m0_gnt, e0);
      chk("m1_gnt", m1_gnt, e1);
      chk("read", read, m_rd);
      chk("write", write, m_wr);
      chk("address", address, m_addr);
      chk("data_out", data_out, m_dout);
      chk("m0_rvalid", m0_rvalid, ev0);
      chk("m1_rvalid", m1_rvalid, ev1);
      chk("m0_rdata", m0_rdata, m_rdat0);
      chk("m1_rdata", m1_rdata, m_rdat1);
    end
    if (m0_req === 1'b1 && m0_gnt === 1'b1) gnt_log.push_back(1'b0);
    if (m1_req === 1'b1 && m1_gnt === 1'b1) gnt_log.push_back(1'b1);
    if (m0_rvalid === 1'b1) rv0_log.push_back(m0_rdata);
    if (m1_rvalid === 1'b1) begin rv1_log.push_back(m1_rdata); rv1_cyc.push_back(cyc); end

    if (rst_n !== 1'b1) begin
      pend.delete();
      m_last = 1'b1; m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_dout = '0;
      m_rdat0 = '0; m_rdat1 = '0; m_locked = 1'b0; m_cnt = 0;
    end else begin
      if (e0 || e1) begin
        p    = e1;
        s_we = p ? m1_we : m0_we;
        s_a  = p ? m1_addr : m0_addr;
        s_d  = p ? m1_wdata : m0_wdata;
        m_rd = !s_we; m_wr = s_we; m_addr = s_a; m_dout = s_d;
        if (s_we) ref_mem[s_a] = s_d;
        else pend.push_back('{due: cyc + 2, port: p, d: ref_mem[s_a]});
        m_last = p;
      end else begin
        m_rd = 1'b0; m_wr = 1'b0;
      end
`ifdef ARB_LOCK_EN
      if (m_locked && !m1_lock) begin
        m_locked = 1'b0; m_cnt = 0;
      end else if (e1 && m1_lock) begin
        m_cnt++;
        if (m_cnt >= LMAX) begin m_locked = 1'b0; m_cnt = 0; end
        else m_locked = 1'b1;
      end
`endif
    end
  end

  // ---------------- request drivers ----------------
  typedef struct { bit we; logic [AW-1:0] a; logic [DW-1:0] d; } op_t;
  op_t q0[$], q1[$];
  bit  drv_en = 1'b1, drop_en = 1'b0, acc0, acc1;

  initial begin
    forever begin
      @(negedge clk);
      acc0 = (m0_req === 1'b1) && (m0_gnt === 1'b1);
      acc1 = (m1_req === 1'b1) && (m1_gnt === 1'b1);
      @(posedge clk);
      #1;
      if (drv_en) begin
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        m0_req = (q0.size() > 0) && !(drop_en && $urandom_range(0, 3) == 0);
        m1_req = (q1.size() > 0) && !(drop_en && $urandom_range(0, 3) == 0);
        if (q0.size() > 0) begin m0_we = q0[0].we; m0_addr = q0[0].a; m0_wdata = q0[0].d; end
        if (q1.size() > 0) begin m1_we = q1[0].we; m1_addr = q1[0].a; m1_wdata = q1[0].d; end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input bit port, input bit we, input int a, input logic [DW-1:0] d);
    op_t o;
    o.we = we; o.a = AW'(a); o.d = d;
    if (port) q1.push_back(o); else q0.push_back(o);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0) && k < 500) begin step(1); k++; end
    if (k >= 500) begin
      n_tests++; n_fail++;
      $display("FAIL %s: queues not drained, got %0d/%0d left, required 0", name, q0.size(), q1.size());
      q0.delete(); q1.delete();
    end
    step(4);
  endtask

  task automatic clear_logs();
    gnt_log.delete(); rv0_log.delete(); rv1_log.delete(); rv1_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  op_t ro;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = DW'(i) * 32'h11;
      ref_mem[i] = DW'(i) * 32'h11;
    end
    step(3);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rdata", m1_rdata, 0);

    // port 0 only: write then read back
    clear_logs();
    push(0, 1, 'h010, 32'h0000_00A5);
    push(0, 0, 'h010, 0);
    drain("t1");
    chk("t1_rv0_count", rv0_log.size(), 1);
    if (rv0_log.size() > 0) chk("t1_rdata", rv0_log[0], 32'h0000_00A5);
    chk("t1_rv1_count", rv1_log.size(), 0);
    chk("t1_gnt_count", gnt_log.size(), 2);

    // both ports read continuously: grants must alternate from port 0
    do_reset();
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      push(0, 0, 'h020 + k, 0);
      push(1, 0, 'h030 + k, 0);
    end
    drain("t2");
    chk("t2_gnt_count", gnt_log.size(), 6);
    for (int k = 0; k < 6; k++)
      if (gnt_log.size() > k) chk("t2_gnt_order", gnt_log[k], k % 2);
    for (int k = 0; k < 3; k++) begin
      if (rv0_log.size() > k) chk("t2_rv0", rv0_log[k], (32'h20 + k) * 32'h11);
      if (rv1_log.size() > k) chk("t2_rv1", rv1_log[k], (32'h30 + k) * 32'h11);
    end

    // port 1 back-to-back reads of preloaded 0x11..0x44
    clear_logs();
    for (int k = 1; k <= 4; k++) push(1, 0, k, 0);
    drain("t3");
    chk("t3_rv1_count", rv1_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (rv1_log.size() > k) begin
        chk("t3_rdata", rv1_log[k], 32'h11 * (k + 1));
        chk("t3_consecutive", rv1_cyc[k], rv1_cyc[0] + k);
      end

    // reset one cycle after a port 0 read is accepted
    clear_logs();
    push(0, 0, 'h005, 0);
    begin
      int k = 0;
      while (q0.size() > 0 && k < 50) begin step(1); k++; end
      chk("t4_accept_timeout", k < 50, 1);
    end
    rst_n = 1'b0;
    step(1);
    chk("t4_read_after_rst", read, 0);
    chk("t4_write_after_rst", write, 0);
    chk("t4_rvalid_after_rst", m0_rvalid, 0);
    step(1);
    rst_n = 1'b1;
    step(4);
    chk("t4_no_rvalid", rv0_log.size(), 0);
    clear_logs();
    push(0, 0, 'h006, 0);
    push(1, 0, 'h007, 0);
    drain("t4b");
    if (gnt_log.size() > 0) chk("t4_first_winner", gnt_log[0], 0);
    else chk("t4_first_winner_count", gnt_log.size(), 2);

    // port 0 drops req while port 1 owns the slot
    clear_logs();
    drv_en = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 'h006; m1_req = 1'b0;
    step(1);
    m0_addr = 'h007; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 'h008;
    step(1);
    m0_req = 1'b0; m1_req = 1'b0;
    step(1);
    step(1);
    chk("t6_no_read", read, 0);
    chk("t6_no_write", write, 0);
    m0_req = 1'b1; m0_addr = 'h009; m1_req = 1'b1;
    step(1);
    m0_req = 1'b0; m1_req = 1'b0;
    drv_en = 1'b1;
    step(3);
    chk("t6_gnt_count", gnt_log.size(), 3);
    if (gnt_log.size() == 3) begin
      chk("t6_gnt0", gnt_log[0], 0);
      chk("t6_gnt1", gnt_log[1], 1);
      chk("t6_gnt2", gnt_log[2], 0);
    end

`ifdef ARB_LOCK_EN
    // lock held by port 1: LOCK_MAX grants, then port 0 gets in
    clear_logs();
    m1_lock = 1'b1;
    for (int k = 0; k < 6; k++) push(1, 0, 'h040 + k, 0);
    for (int k = 0; k < 2; k++) push(0, 0, 'h050 + k, 0);
    drain("t5");
    m1_lock = 1'b0;
    for (int k = 0; k < 5; k++)
      if (gnt_log.size() > k) chk("t5_lock_order", gnt_log[k], (k < 4) ? 1 : 0);
`endif

    // randomized traffic with drops and small address range for read-after-write
    drop_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (q0.size() < 3 && $urandom_range(0, 2) == 0) begin
        ro.we = $urandom_range(0, 1); ro.a = AW'($urandom_range(0, 15)); ro.d = $urandom;
        q0.push_back(ro);
      end
      if (q1.size() < 3 && $urandom_range(0, 2) == 0) begin
        ro.we = $urandom_range(0, 1); ro.a = AW'($urandom_range(0, 15)); ro.d = $urandom;
        q1.push_back(ro);
      end
`ifdef ARB_LOCK_EN
      m1_lock = ($urandom_range(0, 3) != 0);
`endif
      step(1);
    end
    drop_en = 1'b0;
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter that shares the single-port sram between seq_core (port 0) and a second bus master such as a DMA or debug loader (port 1).
- Accepts requests with a req/gnt handshake and selects between ports round-robin.
- Registers the selected access onto the sram read/write strobes.
- Routes read data back to the originating port, tagged with an rvalid pulse.

Parameters:
- D_SIZE, 32, data width (matches `D_SIZE)
- A_SIZE, 10, address width (matches `A_SIZE)
- LOCK_MAX, 16, max consecutive port-1 grants under lock (used only with ARB_LOCK_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- m0_req  in  1  port 0 access request
- m0_we  in  1  port 0: 1=write, 0=read
- m0_addr  in  A_SIZE  port 0 address
- m0_wdata  in  D_SIZE  port 0 write data
- m0_gnt  out  1  port 0 request accepted this cycle
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  D_SIZE  port 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- m1_lock  in  1  port 1 lock request (ARB_LOCK_EN only)
- read  out  1  sram read strobe
- write  out  1  sram write strobe
- address  out  A_SIZE  sram address
- data_out  out  D_SIZE  sram write data
- data_in  in  D_SIZE  sram read data, valid one cycle after read

Behaviour:
- Reset values: read, write, address, data_out, m0_rvalid, m1_rvalid and both rdata outputs are all 0. last_owner=1, so port 0 wins the first contention. Tag pipeline is cleared.
- Handshake:
  - A requester holds req/we/addr/wdata stable until gnt.
  - Transfer occurs when req & gnt are both high at a rising edge.
  - gnt is combinational from req and the state; at most one gnt is high per cycle.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port != last_owner. last_owner updates on every accepted transfer.
- Throughput: one accepted access per cycle, back-to-back, with no bubbles.
- Issue timing: an access accepted at edge N drives read/write/address/data_out in cycle N+1, as registered outputs. With no acceptance, read=write=0 and address/data_out hold their values.
- Read return:
  - The owner tag is shifted through a 2-stage pipeline alongside the read flag.
  - At cycle N+2 the owner's rvalid=1 for one cycle, and its rdata = data_in.
  - The non-owner's rvalid=0 and its rdata holds its last value.
- Writes produce no rvalid.
- Ordering: read data returns in acceptance order. A write followed by a read to the same address returns the new data.
- Simultaneous events: rvalid for an older read may coincide with gnt for a new access on the same port; both are legal.
- Reset mid-operation: in-flight reads are dropped and no rvalid follows. Strobes deassert in the first cycle after the reset edge.
- req dropped without gnt: no effect on state.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - If port 1 is granted while m1_lock=1, the arbiter enters LOCKED.
  - In LOCKED, m0_gnt=0 and port 1 is granted whenever it requests.
  - LOCKED is left when m1_lock falls, or after LOCK_MAX port-1 grants counted since entry; the counter resets on exit.
  - When LOCKED ends on the LOCK_MAX limit, the next contention goes to port 0.
- Undefined: the m1_lock port and the lock counter are absent; pure round-robin.

Decomposition:
- Shared defines include: `D_SIZE, `A_SIZE, owner encodings OWNER_M0=0 / OWNER_M1=1, and the state encodings IDLE/LOCKED.
- One natural sub-module, rr_pick: combinational 2-way round-robin selector taking req[1:0] and last_owner, producing gnt[1:0] and the winner.

Test Plan:
- Port 0 only: write 0x0000_00A5 to address 0x010, then read 0x010. Required: m0_gnt each cycle, write=1 at N+1, m0_rvalid at N+2 of the read with m0_rdata=0x0000_00A5, m1_rvalid=0 throughout.
- Both request reads every cycle for 6 cycles. Required: grants alternate 0,1,0,1,0,1, and each rvalid arrives 2 cycles after its gnt with the data of the matching address.
- Back-to-back reads to addresses 0x001..0x004 from port 1, preloaded with 0x11..0x44. Required: 4 consecutive m1_rvalid cycles returning 0x11, 0x22, 0x33, 0x44.
- Assert rst_n=0 one cycle after accepting a port 0 read. Required: no m0_rvalid follows; read/write=0 on the next cycle; the first post-reset contention is granted to port 0.
- With ARB_LOCK_EN, LOCK_MAX=4: port 1 requests continuously with lock held while port 0 requests. Required: four m1_gnt cycles, then m0_gnt.
- req pulled low without a grant (port 0 while port 1 owns the slot). Required: no sram strobe for port 0 and no change to last_owner.
